fp32_to_bf16_cvt: RTL
=====================

// Module: fp32_to_bf16_cvt
// PURPOSE
//  Streaming narrowing converter: accepts IEEE fp32 words (e.g. FMul mul_out products) and emits
//  bf16 words with round-to-nearest-even, so results can be written back in the 16-bit operand format.
//  2-stage pipeline, valid/ready on both sides, sticky exception flags, transfer counter.
//  Sits between the multiplier/accumulator datapath and the bf16 result writeback.
// PARAMETERS
//  SATURATE  0   1: overflow gives max finite (sign,0x7F7F); 0: overflow gives signed infinity
//  COUNT_W   16  width of cvt_count
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        fp32 word on in_data is valid
//  in_ready   out  1        converter can accept; transfer when in_valid && in_ready
//  in_data    in   32       fp32: [31] sign, [30:23] exp, [22:0] fraction
//  out_valid  out  1        bf16 result valid
//  out_ready  in   1        downstream accepts; transfer when out_valid && out_ready
//  out_data   out  16       bf16: [15] sign, [14:7] exp, [6:0] fraction
//  clr_flags  in   1        synchronous clear of all sticky flags
//  flg_inexact   out 1      sticky: some emitted result had nonzero discarded bits
//  flg_overflow  out 1      sticky: some finite input rounded to exp 255
//  flg_underflow out 1      sticky: some input with exp 0 and nonzero fraction flushed
//  flg_invalid   out 1      sticky: some input was NaN
//  cvt_count  out  COUNT_W  number of output transfers, wraps modulo 2^COUNT_W
// BEHAVIOUR
//  Reset (async, rst_n low): s1_valid=s2_valid=0, out_valid=0, out_data=0, all flags=0, cvt_count=0.
//  Pipeline: S1 captures in_data; S2 holds rounded result driving out_data. Latency 2 cycles from
//   input transfer to out_valid with out_ready held high; throughput 1 word/cycle.
//  Flow control: adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1
//   (combinational from out_ready). Stall holds S1/S2 contents and out_data stable. No drops, no dups.
//  Rounding (computed S1->S2): hi = in[31:16]; lsb=in[16], g=in[15], st=|in[14:0];
//   up = g && (st || lsb); r = hi + up (carry from fraction ripples into exp, correct for RNE).
//  Special cases, checked in priority order:
//   exp==255, frac!=0 (NaN)  -> {sign,8'hFF,7'h40}; invalid flag; not inexact.
//   exp==255, frac==0 (inf)  -> {sign,8'hFF,7'h00}; no flags.
//   exp==0 (zero/subnormal)  -> {sign,15'h0}; underflow if frac!=0; not inexact.
//   finite, r[14:7]==255     -> SATURATE? {sign,15'h7F7F} : {sign,15'h7F80}; overflow+inexact.
//   otherwise                -> r; inexact if g||st.
//  Flags: set at output transfer of the offending word (out_valid && out_ready), OR-accumulate.
//   clr_flags same cycle as a set: set wins (flag=1 after edge). Flags never clear otherwise.
//  cvt_count increments on each output transfer; all-ones + 1 -> 0.
//  Reset mid-operation: in-flight S1/S2 words discarded; in_ready=1 immediately after deassertion.
//  in_data ignored when !in_valid; out_data only meaningful when out_valid.
// TESTING
//  T1 RNE: in 0x3F808000 -> 0x3F80 (tie, even); 0x3F818000 -> 0x3F82; 0x3F808001 -> 0x3F81; inexact=1.
//  T2 specials: 0x7FA00001 -> 0x7FC0, invalid=1; 0xFF800000 -> 0xFF80; 0x00400000 -> 0x0000, underflow=1.
//  T3 overflow: 0x7F7FFFFF -> 0x7F80 (SATURATE=0) / 0x7F7F (SATURATE=1); overflow=1, inexact=1.
//  T4 backpressure: stream 8 words, out_ready random 50%; outputs in order, none lost/duplicated,
//   out_data stable while out_valid && !out_ready; cvt_count=8 at end; full rate with out_ready=1 (2-cycle latency).
//  T5 flags: clr_flags asserted in the cycle an inexact word transfers -> flg_inexact=1; next cycle clr -> 0.
//  T6 reset mid-flight: rst_n low with S1,S2 full -> out_valid=0, count=0 async; 1st post-reset word correct.

Source files
------------

// File: rtl/fp32_to_bf16_cvt.sv
// fp32 -> bf16 streaming narrowing converter.
// Two pipeline stages, valid/ready handshake on both sides. Results are
// rounded to nearest, ties to even. The block keeps sticky exception flags
// and a count of output transfers.
module fp32_to_bf16_cvt #(
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        out_data,
  input  logic               clr_flags,
  output logic               flg_inexact,
  output logic               flg_overflow,
  output logic               flg_underflow,
  output logic               flg_invalid,
  output logic [COUNT_W-1:0] cvt_count
);

  localparam int unsigned FP32_W = 32;
  localparam int unsigned BF16_W = 16;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [6:0]       QNAN_M  = 7'h40;

  // Stage 1: raw fp32 word
  logic              s1_valid_q, s1_valid_d;
  logic [FP32_W-1:0] s1_data_q,  s1_data_d;

  // Stage 2: rounded bf16 word plus its per-word exception bits
  logic              s2_valid_q, s2_valid_d;
  logic [BF16_W-1:0] s2_data_q,  s2_data_d;
  logic              s2_inx_q,   s2_inx_d;
  logic              s2_ovf_q,   s2_ovf_d;
  logic              s2_unf_q,   s2_unf_d;
  logic              s2_nan_q,   s2_nan_d;

  // Sticky flags and transfer counter
  logic               flg_inx_q, flg_inx_d;
  logic               flg_ovf_q, flg_ovf_d;
  logic               flg_unf_q, flg_unf_d;
  logic               flg_nan_q, flg_nan_d;
  logic [COUNT_W-1:0] cnt_q,     cnt_d;

  // Handshake
  logic adv1_c, adv2_c, in_fire_c, out_fire_c;

  // Rounding datapath (stage 1 -> stage 2)
  logic              sign_c;
  logic [EXP_W-1:0]  exp_c;
  logic [FRAC_W-1:0] frac_c;
  logic [BF16_W-1:0] hi_c;
  logic              lsb_c, grd_c, stk_c, up_c;
  logic [BF16_W-1:0] rnd_c;
  logic [BF16_W-1:0] res_c;
  logic              res_inx_c, res_ovf_c, res_unf_c, res_nan_c;

  // Stage 2 advances when empty or drained. Stage 1 advances when empty
  // or when stage 2 advances. This makes a full pipe run at one word per
  // cycle with no bubbles.
  always_comb begin
    adv2_c     = !s2_valid_q || out_ready;
    adv1_c     = !s1_valid_q || adv2_c;
    in_fire_c  = in_valid && adv1_c;
    out_fire_c = s2_valid_q && out_ready;
  end

  // RNE round of the upper half. A fraction carry rolls into the exponent.
  // Specials are then resolved in priority order.
  always_comb begin
    sign_c = s1_data_q[31];
    exp_c  = s1_data_q[30:23];
    frac_c = s1_data_q[22:0];
    hi_c   = s1_data_q[31:16];
    lsb_c  = s1_data_q[16];
    grd_c  = s1_data_q[15];
    stk_c  = |s1_data_q[14:0];
    up_c   = grd_c && (stk_c || lsb_c);
    rnd_c  = hi_c + BF16_W'(up_c);

    res_c     = rnd_c;
    res_inx_c = grd_c || stk_c;
    res_ovf_c = 1'b0;
    res_unf_c = 1'b0;
    res_nan_c = 1'b0;

    if (exp_c == EXP_MAX && frac_c != '0) begin
      res_c     = {sign_c, EXP_MAX, QNAN_M};
      res_nan_c = 1'b1;
      res_inx_c = 1'b0;
    end else if (exp_c == EXP_MAX) begin
      res_c     = {sign_c, EXP_MAX, 7'h00};
      res_inx_c = 1'b0;
    end else if (exp_c == '0) begin
      res_c     = {sign_c, 15'h0000};
      res_unf_c = (frac_c != '0);
      res_inx_c = 1'b0;
    end else if (rnd_c[14:7] == EXP_MAX) begin
      res_c     = SATURATE ? {sign_c, 15'h7F7F} : {sign_c, 15'h7F80};
      res_ovf_c = 1'b1;
      res_inx_c = 1'b1;
    end
  end

  // Pipeline next-state. Each stage holds its contents while stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_inx_d   = s2_inx_q;
    s2_ovf_d   = s2_ovf_q;
    s2_unf_d   = s2_unf_q;
    s2_nan_d   = s2_nan_q;

    if (adv1_c) begin
      s1_valid_d = in_valid;
    end
    if (in_fire_c) begin
      s1_data_d = in_data;
    end
    if (adv2_c) begin
      s2_valid_d = s1_valid_q;
    end
    if (adv2_c && s1_valid_q) begin
      s2_data_d = res_c;
      s2_inx_d  = res_inx_c;
      s2_ovf_d  = res_ovf_c;
      s2_unf_d  = res_unf_c;
      s2_nan_d  = res_nan_c;
    end
  end

  // Sticky flags are set on output transfer and cleared on request. When
  // both happen in the same cycle, the set wins. The counter wraps.
  always_comb begin
    flg_inx_d = flg_inx_q;
    flg_ovf_d = flg_ovf_q;
    flg_unf_d = flg_unf_q;
    flg_nan_d = flg_nan_q;
    cnt_d     = cnt_q;

    if (clr_flags) begin
      flg_inx_d = 1'b0;
      flg_ovf_d = 1'b0;
      flg_unf_d = 1'b0;
      flg_nan_d = 1'b0;
    end
    if (out_fire_c) begin
      if (s2_inx_q) flg_inx_d = 1'b1;
      if (s2_ovf_q) flg_ovf_d = 1'b1;
      if (s2_unf_q) flg_unf_d = 1'b1;
      if (s2_nan_q) flg_nan_d = 1'b1;
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  // State registers. Reset discards any in-flight words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_inx_q   <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_nan_q   <= 1'b0;
      flg_inx_q  <= 1'b0;
      flg_ovf_q  <= 1'b0;
      flg_unf_q  <= 1'b0;
      flg_nan_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_inx_q   <= s2_inx_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_unf_q   <= s2_unf_d;
      s2_nan_q   <= s2_nan_d;
      flg_inx_q  <= flg_inx_d;
      flg_ovf_q  <= flg_ovf_d;
      flg_unf_q  <= flg_unf_d;
      flg_nan_q  <= flg_nan_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output drive
  always_comb begin
    in_ready      = adv1_c;
    out_valid     = s2_valid_q;
    out_data      = s2_data_q;
    flg_inexact   = flg_inx_q;
    flg_overflow  = flg_ovf_q;
    flg_underflow = flg_unf_q;
    flg_invalid   = flg_nan_q;
    cvt_count     = cnt_q;
  end

endmodule
